// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sched
//  Purpose  : Issues one MULT/MULTU/DIV/DIVU at a time to the shared
//             multiplier/divider. It latches the operands, drives the
//             start/annul handshake, stalls EX while a unit is busy and
//             returns the 64-bit result as hi/lo.
//  Options  : MULDIV_DIVZERO_BYPASS_EN - a divide by zero completes at once
//             with hi=src1 and lo=all-ones, and the divider is never started.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        mul_start,
  output logic        mul_signed,
  output logic        mul_annul,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic        stallreq,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        result_valid,
  output logic        timeout_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic               r_mul_signed;
  logic               r_div_signed;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_result_valid;
  logic               r_timeout_err;

  logic w_legal;
  logic w_is_mul;
  logic w_is_div;
  logic w_signed;
  logic w_idle;
  logic w_mul_run;
  logic w_div_run;
  logic w_run;
  logic w_ready;
  logic w_timeout;
  logic w_div_zero;

  // Exactly one op_code bit set qualifies as an issue; anything else is a no-op.
  assign w_legal   = op_valid && (op_code != 4'd0) && ((op_code & (op_code - 4'd1)) == 4'd0);
  assign w_is_mul  = op_code[0] | op_code[1];
  assign w_is_div  = op_code[2] | op_code[3];
  assign w_signed  = op_code[0] | op_code[2];

  assign w_idle    = (r_state == S_IDLE);
  assign w_mul_run = (r_state == S_MUL_RUN);
  assign w_div_run = (r_state == S_DIV_RUN);
  assign w_run     = w_mul_run | w_div_run;
  // Only the ready of the unit actually running is honoured.
  assign w_ready   = (w_mul_run & mul_ready) | (w_div_run & div_ready);
  assign w_timeout = w_run & ~w_ready & (r_cnt == c_CNT_LAST);

`ifdef MULDIV_DIVZERO_BYPASS_EN
  assign w_div_zero = w_is_div & (src2 == 32'd0);
`else
  assign w_div_zero = 1'b0;
`endif

  // Handshake and stall are combinational so they react in the same cycle as ready/flush.
  assign stallreq  = resetn & ~flush & ((w_idle & w_legal) | (w_run & ~w_ready));
  assign mul_start = resetn & w_mul_run & ~mul_ready & ~flush & ~w_timeout;
  assign div_start = resetn & w_div_run & ~div_ready & ~flush & ~w_timeout;
  assign mul_annul = resetn & w_mul_run & (flush | w_timeout);
  assign div_annul = resetn & w_div_run & (flush | w_timeout);

  assign op1_o        = r_op1;
  assign op2_o        = r_op2;
  assign mul_signed   = r_mul_signed;
  assign div_signed   = r_div_signed;
  assign hi_result    = r_hi;
  assign lo_result    = r_lo;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;

  // Sequencer: issue, wait for ready or timeout, hold result until EX advances.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op1          <= '0;
      r_op2          <= '0;
      r_mul_signed   <= 1'b0;
      r_div_signed   <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else if (flush) begin
      // Abandon whatever is in flight; a partial result is never captured.
      r_state        <= S_IDLE;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_op1        <= src1;
            r_op2        <= src2;
            r_mul_signed <= w_is_mul & w_signed;
            r_div_signed <= w_is_div & w_signed;
            r_cnt        <= '0;
            if (w_div_zero) begin
              r_hi           <= src1;
              r_lo           <= 32'hFFFF_FFFF;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else if (w_is_mul) begin
              r_state <= S_MUL_RUN;
            end else begin
              r_state <= S_DIV_RUN;
            end
          end
        end
        S_MUL_RUN, S_DIV_RUN: begin
          if (w_ready) begin
            r_hi           <= w_mul_run ? mul_result[63:32] : div_result[63:32];
            r_lo           <= w_mul_run ? mul_result[31:0]  : div_result[31:0];
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else if (w_timeout) begin
            r_hi           <= '0;
            r_lo           <= '0;
            r_timeout_err  <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_DONE: begin
          // A new op presented together with ex_advance issues from IDLE next cycle.
          if (ex_advance) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sched
//  Purpose  : Directed self-checking bench for muldiv_sched (TIMEOUT_CYCLES=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ex_advance;
  logic        flush;
  logic        mul_start;
  logic        mul_signed;
  logic        mul_annul;
  logic        mul_ready;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic        stallreq;
  logic [31:0] hi_result;
  logic [31:0] lo_result;
  logic        result_valid;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_sched #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .src1         (src1),
    .src2         (src2),
    .ex_advance   (ex_advance),
    .flush        (flush),
    .mul_start    (mul_start),
    .mul_signed   (mul_signed),
    .mul_annul    (mul_annul),
    .mul_ready    (mul_ready),
    .mul_result   (mul_result),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_annul    (div_annul),
    .div_ready    (div_ready),
    .div_result   (div_result),
    .op1_o        (op1_o),
    .op2_o        (op2_o),
    .stallreq     (stallreq),
    .hi_result    (hi_result),
    .lo_result    (lo_result),
    .result_valid (result_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one op, let the unit answer after n start cycles, check result, retire it.
  task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [63:0] res,
                       input logic exp_signed);
    int   stalls;
    logic is_mul;
    is_mul   = (code[1:0] != 2'b00);
    stalls   = 0;
    op_valid = 1'b1; op_code = code; src1 = a; src2 = b;
    #1;
    if (stallreq) stalls++;
    check({tag, "_issue_start"}, {62'd0, mul_start, div_start}, 64'd0);
    for (int k = 1; k <= n + 1; k++) begin
      step();
      if (is_mul) begin
        mul_ready = (k == n + 1); mul_result = res; div_result = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        div_ready = (k == n + 1); div_result = res; mul_result = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      #1;
      if (stallreq) stalls++;
      if (k == 1) begin
        check({tag, "_start"}, {62'd0, mul_start, div_start}, is_mul ? 64'd2 : 64'd1);
        check({tag, "_signed"}, {62'd0, mul_signed, div_signed},
              is_mul ? {62'd0, exp_signed, 1'b0} : {63'd0, exp_signed});
        check({tag, "_ops"}, {op1_o, op2_o}, {a, b});
      end
    end
    step();
    mul_ready = 1'b0; div_ready = 1'b0;
    #1;
    check({tag, "_stalls"}, 64'(stalls), 64'(n + 1));
    check({tag, "_valid"}, {63'd0, result_valid}, 64'd1);
    check({tag, "_hilo"}, {hi_result, lo_result}, res);
    check({tag, "_done_stall"}, {63'd0, stallreq}, 64'd0);
    step();
    check({tag, "_hold"}, {63'd0, result_valid}, 64'd1);
    ex_advance = 1'b1;
    step();
    ex_advance = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    #1;
    check({tag, "_retired"}, {62'd0, result_valid, stallreq}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_code = 4'd0; src1 = '0; src2 = '0;
    ex_advance = 1'b0; flush = 1'b0; mul_ready = 1'b0; div_ready = 1'b0;
    mul_result = '0; div_result = '0;

    // Reset
    step(); step();
    #1;
    check("rst_ctrl", {57'd0, stallreq, mul_start, div_start, mul_annul, div_annul, mul_signed, div_signed}, 64'd0);
    check("rst_ops", {op1_o, op2_o}, 64'd0);
    check("rst_hilo", {hi_result, lo_result}, 64'd0);
    check("rst_flags", {62'd0, result_valid, timeout_err}, 64'd0);
    resetn = 1'b1;
    step();

    // MULT -3 x 5, answer after 4 start cycles -> 5 stall cycles
    do_op("mult", 4'b0001, 32'hFFFF_FFFD, 32'd5, 4, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    // DIVU 100/7 -> rem 2, quot 14
    do_op("divu", 4'b1000, 32'd100, 32'd7, 3, {32'd2, 32'd14}, 1'b0);
    // DIV -7/2 -> rem -1, quot -3
    do_op("div", 4'b0100, 32'hFFFF_FFF9, 32'd2, 3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

    // Flush two cycles into MUL_RUN
    step();
    op_valid = 1'b1; op_code = 4'b0010; src1 = 32'd6; src2 = 32'd7;
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush_annul", {62'd0, mul_annul, div_annul}, 64'd2);
    check("flush_stall", {63'd0, stallreq}, 64'd0);
    step();
    flush = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    #1;
    check("flush_idle", {60'd0, mul_start, mul_annul, stallreq, result_valid}, 64'd0);
    // A stray ready while idle must not touch the result
    mul_ready = 1'b1; mul_result = 64'h1234_5678_9ABC_DEF0;
    step();
    mul_ready = 1'b0;
    #1;
    check("stray_ready", {hi_result, lo_result}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("stray_valid", {63'd0, result_valid}, 64'd0);

    // Timeout: DIVU with the divider never answering
    op_valid = 1'b1; op_code = 4'b1000; src1 = 32'd50; src2 = 32'd5;
    for (int k = 1; k <= 8; k++) begin
      step();
      #1;
      if (k < 8) check("to_wait", {61'd0, div_start, div_annul, timeout_err}, 64'd4);
      else       check("to_annul", {61'd0, div_start, div_annul, timeout_err}, 64'd2);
    end
    step();
    #1;
    check("to_done", {61'd0, result_valid, timeout_err, div_annul}, 64'd6);
    check("to_hilo", {hi_result, lo_result}, 64'd0);
    ex_advance = 1'b1;
    step();
    ex_advance = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    #1;
    check("to_sticky", {62'd0, timeout_err, result_valid}, 64'd2);

    // Illegal op_code is a no-op
    op_valid = 1'b1; op_code = 4'b0101; src1 = 32'd1; src2 = 32'd1;
    #1;
    check("ill_stall", {63'd0, stallreq}, 64'd0);
    step();
    #1;
    check("ill_start", {61'd0, mul_start, div_start, stallreq}, 64'd0);
    op_valid = 1'b0; op_code = 4'b0001;
    #1;
    check("noval_stall", {63'd0, stallreq}, 64'd0);
    op_code = 4'd0;
    step();

`ifdef MULDIV_DIVZERO_BYPASS_EN
    // DIVU 9/0 completes without the divider
    op_valid = 1'b1; op_code = 4'b1000; src1 = 32'd9; src2 = 32'd0;
    #1;
    check("dz_issue_stall", {62'd0, stallreq, div_start}, 64'd2);
    step();
    #1;
    check("dz_done", {61'd0, stallreq, div_start, result_valid}, 64'd1);
    check("dz_hilo", {hi_result, lo_result}, {32'd9, 32'hFFFF_FFFF});
    ex_advance = 1'b1;
    step();
    ex_advance = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    #1;
    check("dz_retired", {63'd0, result_valid}, 64'd0);
`else
    // Zero divisor goes to the divider like any other operand
    do_op("dz", 4'b1000, 32'd9, 32'd0, 1, {32'd9, 32'hFFFF_FFFF}, 1'b0);
`endif

    // Reset clears the sticky timeout flag
    resetn = 1'b0;
    step();
    #1;
    check("rst2_err", {63'd0, timeout_err}, 64'd0);
    resetn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
